// File: rtl/rect_bank_rd_if.sv
// rect_bank_rd_if: stream bundle between the feature address generator
// (master), rect_bank_rd (slave) and the feature evaluation pipeline.
//   flush        master->slave  sync discard of in-flight and buffered words
//   addr_valid   master->slave  address stream valid
//   addr_ready   slave->master  address stream ready
//   addr_data    master->slave  ROM address, shared by all lanes
//   data_valid   slave->master  output stream valid
//   data_ready   master->slave  output stream ready
//   data         slave->master  lane k at [k*W_DATA +: W_DATA]
//   outstanding  slave->master  in-flight plus buffered word count
interface rect_bank_rd_if #(
   parameter int W_DATA     = 20,
   parameter int W_ADDR     = 14,
   parameter int N_RECT     = 3,
   parameter int ROM_LAT    = 1,
   parameter int FIFO_DEPTH = ROM_LAT + 2
);
   localparam int W_CNT = $clog2(FIFO_DEPTH + 1);

   logic                       flush;
   logic                       addr_valid;
   logic                       addr_ready;
   logic [W_ADDR-1:0]          addr_data;
   logic                       data_valid;
   logic                       data_ready;
   logic [N_RECT*W_DATA-1:0]   data;
   logic [W_CNT-1:0]           outstanding;

   modport slave (
      input  flush, addr_valid, addr_data, data_ready,
      output addr_ready, data_valid, data, outstanding
   );

   modport master (
      output flush, addr_valid, addr_data, data_ready,
      input  addr_ready, data_valid, data, outstanding
   );
endinterface

// File: rtl/rect_bank_rd.sv
// rect_bank_rd: multi-lane read front-end for the rectangle coefficient ROMs.
// One address stream drives N_RECT ROM lanes in lock-step; the concatenated
// lane words land in a credit-protected FIFO and leave over a valid/ready
// stream. flush discards everything in flight and buffered.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-low reset
//   bus   rect_bank_rd_if.slave (see interface file for signal list)
// Lane k (rect{k}_rom) image: word(a) = a*(2k+3) + (k+1)*0x0F0F mod 2^W_DATA.

// One ROM lane: registered read on en, then ROM_LAT-1 plain delay stages.
module rect_rom_lane #(
   parameter int K      = 0,
   parameter int W_DATA = 20,
   parameter int W_ADDR = 14,
   parameter int LAT    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_en,
   input  logic [W_ADDR-1:0] i_addr,
   output logic [W_DATA-1:0] o_q
);
   localparam logic [W_DATA-1:0] MUL = W_DATA'(2 * K + 3);
   localparam logic [W_DATA-1:0] OFS = W_DATA'((K + 1) * 32'h0F0F);

   logic [W_DATA-1:0]          w_rom;
   logic [LAT-1:0][W_DATA-1:0] r_q;

   assign w_rom = W_DATA'(i_addr) * MUL + OFS;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_q <= '0;
      end else begin
         if (i_en) r_q[0] <= w_rom;
         for (int i = 1; i < LAT; i++) r_q[i] <= r_q[i-1];
      end
   end

   assign o_q = r_q[LAT-1];
endmodule

module rect_bank_rd #(
   parameter int W_DATA     = 20,
   parameter int W_ADDR     = 14,
   parameter int N_RECT     = 3,
   parameter int ROM_LAT    = 1,
   parameter int FIFO_DEPTH = ROM_LAT + 2
) (
   input  logic          clk,
   input  logic          rst,
   rect_bank_rd_if.slave bus
);
   localparam int W_OUT = N_RECT * W_DATA;
   localparam int W_CNT = $clog2(FIFO_DEPTH + 1);
   localparam int W_PTR = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [W_CNT-1:0] DEPTH_C = W_CNT'(FIFO_DEPTH);
   localparam logic [W_PTR-1:0] LAST_P  = W_PTR'(FIFO_DEPTH - 1);

   logic               r_addr_ready;
   logic [W_CNT-1:0]   r_out, w_out_nxt;
   logic [ROM_LAT:1]   vld_pipe;
   logic [W_OUT-1:0]   w_lane_q;
   logic [W_OUT-1:0]   r_mem [FIFO_DEPTH];
   logic [W_PTR-1:0]   r_wptr, r_rptr;
   logic [W_CNT-1:0]   r_fcnt;
   logic               w_acc, w_pop, w_wr, w_empty, w_full;

   // flush outranks both handshakes in its cycle
   assign w_acc   = bus.addr_valid & r_addr_ready & ~bus.flush;
   assign w_empty = (r_fcnt == '0);
   assign w_full  = (r_fcnt == DEPTH_C);
   assign w_pop   = ~w_empty & bus.data_ready & ~bus.flush;
   assign w_wr    = vld_pipe[ROM_LAT] & ~bus.flush;

   // ---- credits: every accepted read owns a FIFO slot until popped ----
   always_comb begin
      w_out_nxt = r_out;
      case ({w_acc, w_pop})
         2'b10:   w_out_nxt = r_out + 1'b1;
         2'b01:   w_out_nxt = r_out - 1'b1;
         default: w_out_nxt = r_out;
      endcase
   end

   // Ready is computed from next-state credits and registered, so it never
   // depends combinationally on data_ready or addr_valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out        <= '0;
         r_addr_ready <= 1'b0;
      end else if (bus.flush) begin
         r_out        <= '0;
         r_addr_ready <= 1'b1;
      end else begin
         r_out        <= w_out_nxt;
         r_addr_ready <= (w_out_nxt < DEPTH_C);
      end
   end

   // ---- valid bit riding alongside the ROM read ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe <= '0;
      end else if (bus.flush) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[1] <= w_acc;
         for (int s = 2; s <= ROM_LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
      end
   end

   // ---- ROM lanes ----
   for (genvar k = 0; k < N_RECT; k++) begin : g_lane
      rect_rom_lane #(
         .K      (k),
         .W_DATA (W_DATA),
         .W_ADDR (W_ADDR),
         .LAT    (ROM_LAT)
      ) u_lane (
         .clk    (clk),
         .rst    (rst),
         .i_en   (w_acc),
         .i_addr (bus.addr_data),
         .o_q    (w_lane_q[k*W_DATA +: W_DATA])
      );
   end

   // ---- output FIFO ----
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_fcnt <= '0;
      end else if (bus.flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_fcnt <= '0;
      end else begin
         if (w_wr)  r_wptr <= (r_wptr == LAST_P) ? '0 : r_wptr + 1'b1;
         if (w_pop) r_rptr <= (r_rptr == LAST_P) ? '0 : r_rptr + 1'b1;
         case ({w_wr, w_pop})
            2'b10:   r_fcnt <= r_fcnt + 1'b1;
            2'b01:   r_fcnt <= r_fcnt - 1'b1;
            default: r_fcnt <= r_fcnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= w_lane_q;
   end

   // Credits bound in-flight + buffered words by FIFO_DEPTH, so a write can
   // never meet a full FIFO.
   ap_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(w_wr && w_full));

   // Head is masked to zero when empty so data reads 0 after reset/flush.
   assign bus.addr_ready  = r_addr_ready & ~bus.flush;
   assign bus.data_valid  = ~w_empty;
   assign bus.data        = w_empty ? '0 : r_mem[r_rptr];
   assign bus.outstanding = r_out;
endmodule

// File: tb/tb_rect_bank_rd.sv
module tb_rect_bank_rd;
   localparam int W_DATA  = 20;
   localparam int W_ADDR  = 14;
   localparam int N_RECT  = 3;
   localparam int ROM_LAT = 2;
   localparam int DEPTH   = ROM_LAT + 2;
   localparam int W_OUT   = N_RECT * W_DATA;
   localparam int W_CNT   = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rect_bank_rd_if #(.W_DATA(W_DATA), .W_ADDR(W_ADDR), .N_RECT(N_RECT),
                     .ROM_LAT(ROM_LAT), .FIFO_DEPTH(DEPTH)) bus ();

   rect_bank_rd #(.W_DATA(W_DATA), .W_ADDR(W_ADDR), .N_RECT(N_RECT),
                  .ROM_LAT(ROM_LAT), .FIFO_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   int n_pop  = 0;
   logic [W_OUT-1:0] exp_q [$];

   logic             obs_ready, obs_valid;
   logic [W_CNT-1:0] obs_out;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Reference: each lane ROM word computed straight from the lane formula.
   function automatic logic [W_OUT-1:0] model(input int a);
      logic [W_OUT-1:0] w;
      w = '0;
      for (int k = 0; k < N_RECT; k++)
         w[k*W_DATA +: W_DATA] = W_DATA'((a * (2*k + 3) + (k + 1) * 'h0F0F) % (1 << W_DATA));
      return w;
   endfunction

   // Output monitor: pops the scoreboard whenever a word is taken.
   logic             hold_q = 1'b0;
   logic [W_OUT-1:0] hold_d = '0;
   always @(negedge clk) begin
      if (!rst) begin
         hold_q = 1'b0;
      end else begin
         if (hold_q && bus.data_valid) chk("hold_stable", 64'(bus.data), 64'(hold_d));
         hold_q = bus.data_valid && !bus.data_ready && !bus.flush;
         hold_d = bus.data;
         if (bus.data_valid && bus.data_ready && !bus.flush) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_word: got %0h, required no word", bus.data);
            end else begin
               chk("data", 64'(bus.data), 64'(exp_q.pop_front()));
               n_pop++;
            end
         end
      end
   end

   // One cycle of stimulus; starts and ends 1 time unit after a rising edge.
   task automatic step(input bit v, input int a, input bit rdy, input bit fl, output bit acc);
      bus.addr_valid = v;
      bus.addr_data  = W_ADDR'(a);
      bus.data_ready = rdy;
      bus.flush      = fl;
      @(negedge clk);
      obs_ready = bus.addr_ready;
      obs_valid = bus.data_valid;
      obs_out   = bus.outstanding;
      acc = v && bus.addr_ready;
      if (acc) exp_q.push_back(model(a));
      if (fl)  exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   function automatic int ra();
      return int'($urandom_range(0, (1 << W_ADDR) - 1));
   endfunction

   initial begin
      bit acc;
      int n, p0;
      bus.flush = 0; bus.addr_valid = 0; bus.addr_data = '0; bus.data_ready = 0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_addr_ready", 64'(bus.addr_ready), 0);
      chk("rst_data_valid", 64'(bus.data_valid), 0);
      chk("rst_data", 64'(bus.data), 0);
      chk("rst_outstanding", 64'(bus.outstanding), 0);
      @(posedge clk); #1 rst = 1'b1;
      step(0, 0, 1, 0, acc);
      step(0, 0, 1, 0, acc);
      chk("ready_after_reset", 64'(obs_ready), 1);

      // single read, latency ROM_LAT+1
      p0 = n_pop;
      step(1, 'h005, 1, 0, acc);
      chk("t1_accept", 64'(acc), 1);
      for (int d = 1; d <= ROM_LAT; d++) begin
         step(0, 0, 1, 0, acc);
         chk("t1_not_yet_valid", 64'(obs_valid), 0);
      end
      step(0, 0, 1, 0, acc);
      chk("t1_valid_at_lat", 64'(obs_valid), 1);
      chk("t1_popped", 64'(n_pop - p0), 1);

      // streaming 64 words
      p0 = n_pop; n = 0;
      for (int i = 0; i < 64; i++) begin
         step(1, ra(), 1, 0, acc);
         if (!acc) n++;
      end
      chk("t2_ready_drops", 64'(n), 0);
      for (int d = 0; d <= ROM_LAT; d++) step(0, 0, 1, 0, acc);
      chk("t2_all_delivered", 64'(n_pop - p0), 64);

      // backpressure
      n = 0;
      for (int i = 0; i < 10; i++) begin
         step(1, ra(), 0, 0, acc);
         n += int'(acc);
      end
      chk("t3_accepts", 64'(n), DEPTH);
      chk("t3_ready_low", 64'(obs_ready), 0);
      chk("t3_outstanding", 64'(obs_out), DEPTH);
      p0 = n_pop;
      for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 1, 0, acc);
      chk("t3_released", 64'(n_pop - p0), DEPTH);
      chk("t3_out_zero", 64'(obs_out), 0);

      // accept + pop at DEPTH-1
      for (int i = 0; i < DEPTH - 1; i++) step(1, ra(), 0, 0, acc);
      for (int d = 0; d <= ROM_LAT; d++) step(0, 0, 0, 0, acc);
      chk("t4_out_pre", 64'(obs_out), DEPTH - 1);
      p0 = n_pop;
      step(1, ra(), 1, 0, acc);
      chk("t4_accept", 64'(acc), 1);
      chk("t4_pop", 64'(n_pop - p0), 1);
      step(0, 0, 0, 0, acc);
      chk("t4_out_same", 64'(obs_out), DEPTH - 1);
      chk("t4_ready_kept", 64'(obs_ready), 1);
      for (int i = 0; i < DEPTH + ROM_LAT + 2; i++) step(0, 0, 1, 0, acc);
      chk("t4_drained", 64'(exp_q.size()), 0);

      // flush with 2 in flight + 2 buffered; a pop coincides with flush
      n = 0;
      for (int i = 0; i < 4; i++) begin
         step(1, ra(), 0, 0, acc);
         n += int'(acc);
      end
      chk("t5_accepts", 64'(n), 4);
      p0 = n_pop;
      step(1, ra(), 1, 1, acc);
      chk("t5_no_accept_in_flush", 64'(acc), 0);
      step(0, 0, 1, 0, acc);
      chk("t5_valid_cleared", 64'(obs_valid), 0);
      chk("t5_out_cleared", 64'(obs_out), 0);
      chk("t5_ready_back", 64'(obs_ready), 1);
      for (int i = 0; i < 8; i++) step(0, 0, 1, 0, acc);
      chk("t5_none_emerged", 64'(n_pop - p0), 0);

      // flush forces addr_ready low even with credits free
      step(1, ra(), 1, 0, acc);
      step(1, ra(), 1, 1, acc);
      chk("t5b_ready_forced_low", 64'(obs_ready), 0);
      p0 = n_pop;
      for (int i = 0; i < 6; i++) step(0, 0, 1, 0, acc);
      chk("t5b_inflight_dropped", 64'(n_pop - p0), 0);

      // async reset mid-stream
      for (int i = 0; i < 5; i++) step(1, ra(), ($urandom % 2) == 1, 0, acc);
      #2 rst = 1'b0;
      #1;
      chk("ar_addr_ready", 64'(bus.addr_ready), 0);
      chk("ar_data_valid", 64'(bus.data_valid), 0);
      chk("ar_data", 64'(bus.data), 0);
      chk("ar_outstanding", 64'(bus.outstanding), 0);
      exp_q.delete();
      bus.addr_valid = 0;
      @(posedge clk); @(posedge clk); #1 rst = 1'b1;
      step(0, 0, 1, 0, acc);
      step(0, 0, 1, 0, acc);
      p0 = n_pop;
      step(1, 'h1A3, 1, 0, acc);
      chk("ar_accept", 64'(acc), 1);
      for (int d = 0; d <= ROM_LAT; d++) step(0, 0, 1, 0, acc);
      chk("ar_first_read", 64'(n_pop - p0), 1);

      // random traffic with occasional flush
      for (int i = 0; i < 400; i++)
         step(($urandom % 4) != 0, ra(), ($urandom % 3) != 0, ($urandom % 50) == 0, acc);
      for (int i = 0; i < 20; i++) step(0, 0, 1, 0, acc);
      chk("rnd_drained", 64'(exp_q.size()), 0);
      chk("rnd_out_zero", 64'(obs_out), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1);
   end
endmodule
